gate_sensor_frontend: RTL and testbench
=======================================

Name: gate_sensor_frontend

Overview:
- Sensor front-end for the turnstile gate controller. It takes the four raw switch/sensor lines (rotation, entry, exit, metal detector), synchronizes and debounces each one, and presents a clean 4-bit sensor word.
- The gate FSM samples this word on every clock, so it sees only settled, glitch-free combinations.
- Also emits a one-cycle change strobe and per-sensor rise/fall pulses for event counting.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from the stable value before the stable value is updated. Legal range ≥1.
- SYNC_STAGES, 2: flip-flop depth of each input synchronizer. Legal range ≥2.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- raw_giro  input  1  raw rotation sensor, asynchronous
- raw_entrada  input  1  raw entry sensor, asynchronous
- raw_saida  input  1  raw exit sensor, asynchronous
- raw_metais  input  1  raw metal detector, asynchronous
- sensor_word  output  4  debounced word: [3]=giro, [2]=entrada, [1]=saida, [0]=metais
- word_changed  output  1  one-cycle pulse when sensor_word differs from its previous value
- rise  output  4  per-bit one-cycle pulse on 0→1 of the matching sensor_word bit
- fall  output  4  per-bit one-cycle pulse on 1→0 of the matching sensor_word bit

Behaviour:
- Reset (reset_n low): applied asynchronously. Clears all synchronizer flops, debounce counters and stable values to 0. Outputs while in reset: sensor_word=4'b0000, word_changed=0, rise=0, fall=0.
- Reset mid-operation: any debounce in progress is discarded. After release, the raw levels are re-acquired from scratch.
- Per-channel pipeline: SYNC_STAGES synchronizer → debounce counter cnt (width clog2(DEBOUNCE_CYCLES+1)) → stable bit.
- Counter rule at each edge, using sync = last synchronizer stage:
  - sync == stable: cnt←0.
  - sync != stable and cnt < DEBOUNCE_CYCLES-1: cnt←cnt+1.
  - sync != stable and cnt == DEBOUNCE_CYCLES-1: stable←sync, cnt←0.
- Latency: a raw level held steady appears on sensor_word exactly L = SYNC_STAGES + DEBOUNCE_CYCLES rising edges after it is first sampled. The first sampling edge counts as edge 1.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) never reaches sensor_word. Any return to the stable level zeroes cnt, so a later change restarts the full count.
- word_changed, rise and fall are registered. They assert in the same cycle sensor_word takes its new value, for exactly one cycle.
  - rise[i] = new[i] & ~old[i]
  - fall[i] = ~new[i] & old[i]
  - word_changed = |(rise|fall)
- Simultaneous events: several channels updating on the same edge produce a single word_changed pulse, with every affected rise/fall bit set together.
- Channels are fully independent. No cross-channel filtering; illegal combinations are passed through for the controller to handle.
- Raw inputs high at reset release: seen as 0→1 after L cycles, with the corresponding rise pulses.
- DEBOUNCE_CYCLES=1: a stable level updates on the first edge of disagreement, so L = SYNC_STAGES+1.
- Back-to-back changes on one channel each require a full DEBOUNCE_CYCLES window. Consecutive pulses on one bit are therefore at least DEBOUNCE_CYCLES cycles apart.

Decomposition:
- Shared package gate_pkg:
  - bit-index constants GIRO=3, ENTRADA=2, SAIDA=1, METAIS=0
  - sensor word width constant (4)
  - sensor word reset value 4'b0000
  - The gate controller uses the same package.
- One sub-module, debounce_channel (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports clock, reset_n, raw, stable). It is instantiated four times.
- Top level holds the previous-word register and the edge/strobe logic.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, so L=6):
- Reset held with all raw=1, then released → sensor_word 0000 for cycles 1–5. sensor_word=1111, rise=1111 and word_changed=1 on edge 6; all pulses return to 0 on edge 7.
- raw_giro 0→1 held → sensor_word[3]=1 on edge 6, rise=1000 for one cycle. Then raw_giro 1→0 held → fall=1000 six edges later.
- raw_metais pulsed high for 3 cycles → sensor_word stays 0000; word_changed never asserts.
- raw_entrada high 3 cycles, low 1 cycle, then high held → update occurs 6 edges after the final rise, not earlier.
- raw_giro and raw_entrada rise on the same edge → one word_changed pulse with rise=1100. sensor_word goes 0000→1100 on edge 6.
- Debounce in progress (cnt=2), then reset_n pulsed low for 1 cycle → outputs go to 0 asynchronously. After release the input takes a full L=6 cycles again.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: definitions shared by the turnstile gate sensor front-end and the
// gate controller.
//   - Bit positions of each sensor inside the 4-bit sensor word.
//   - Sensor word width, type and reset value.
//   - Helper functions for edge detection between two sensor words.
package gate_pkg;

  localparam int SENSOR_W = 4;

  // Bit positions inside the sensor word
  localparam int GIRO    = 3;
  localparam int ENTRADA = 2;
  localparam int SAIDA   = 1;
  localparam int METAIS  = 0;

  typedef logic [SENSOR_W-1:0] sensor_word_t;

  localparam sensor_word_t SENSOR_RESET = 4'b0000;

  // Bits that went 0 -> 1 between old_w and new_w
  function automatic sensor_word_t rise_bits(input sensor_word_t new_w,
                                             input sensor_word_t old_w);
    return new_w & ~old_w;
  endfunction

  // Bits that went 1 -> 0 between old_w and new_w
  function automatic sensor_word_t fall_bits(input sensor_word_t new_w,
                                             input sensor_word_t old_w);
    return ~new_w & old_w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizes one asynchronous raw line and debounces it.
// The stable output only takes a new level after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clock edges.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset (clears synchronizer, counter, stable)
//   raw      raw asynchronous input
//   stable   debounced level
module debounce_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   sync;

  // Oldest stage is the synchronized value used by the debouncer
  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Any agreement with the stable level zeroes the counter, so a bouncing
  // line must restart the whole window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= sync;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/gate_sensor_frontend.sv
// gate_sensor_frontend: synchronizes and debounces the four turnstile sensor
// lines and presents them as one clean word, plus change/edge pulses.
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   raw_giro      raw rotation sensor (async)
//   raw_entrada   raw entry sensor (async)
//   raw_saida     raw exit sensor (async)
//   raw_metais    raw metal detector (async)
//   sensor_word   debounced word [3]=giro [2]=entrada [1]=saida [0]=metais
//   word_changed  one-cycle pulse when sensor_word changes
//   rise          per-bit one-cycle pulse on 0->1 of sensor_word
//   fall          per-bit one-cycle pulse on 1->0 of sensor_word
module gate_sensor_frontend
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                raw_giro,
  input  logic                raw_entrada,
  input  logic                raw_saida,
  input  logic                raw_metais,
  output logic [SENSOR_W-1:0] sensor_word,
  output logic                word_changed,
  output logic [SENSOR_W-1:0] rise,
  output logic [SENSOR_W-1:0] fall
);

  sensor_word_t raw_vec;
  sensor_word_t stable_vec;
  sensor_word_t prev_q;
  sensor_word_t rise_w;
  sensor_word_t fall_w;

  always_comb begin
    raw_vec          = SENSOR_RESET;
    raw_vec[GIRO]    = raw_giro;
    raw_vec[ENTRADA] = raw_entrada;
    raw_vec[SAIDA]   = raw_saida;
    raw_vec[METAIS]  = raw_metais;
  end

  for (genvar i = 0; i < SENSOR_W; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (raw_vec[i]),
      .stable  (stable_vec[i])
    );
  end

  // prev_q trails the stable word by one cycle. The pulses are a pure
  // function of two flop banks, so they line up with the cycle in which
  // sensor_word takes its new value and last exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= SENSOR_RESET;
    end else begin
      prev_q <= stable_vec;
    end
  end

  assign rise_w       = rise_bits(stable_vec, prev_q);
  assign fall_w       = fall_bits(stable_vec, prev_q);
  assign sensor_word  = stable_vec;
  assign rise         = rise_w;
  assign fall         = fall_w;
  assign word_changed = |(rise_w | fall_w);

endmodule

// File: tb/tb_gate_sensor_frontend.sv
module tb_gate_sensor_frontend;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int L    = SYNC + DEB;  // 6

  logic       clock;
  logic       reset_n;
  logic       raw_giro, raw_entrada, raw_saida, raw_metais;
  logic [3:0] sensor_word;
  logic       word_changed;
  logic [3:0] rise, fall;

  int tests_run = 0;
  int failed    = 0;

  gate_sensor_frontend #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .raw_giro     (raw_giro),
    .raw_entrada  (raw_entrada),
    .raw_saida    (raw_saida),
    .raw_metais   (raw_metais),
    .sensor_word  (sensor_word),
    .word_changed (word_changed),
    .rise         (rise),
    .fall         (fall)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_raw(input logic [3:0] v);
    raw_giro    = v[3];
    raw_entrada = v[2];
    raw_saida   = v[1];
    raw_metais  = v[0];
  endtask

  // Walk n edges after a raw change; before edge upd the word is old_w, on edge
  // upd it becomes new_w with the matching pulses, afterwards pulses are 0.
  task automatic run_edges(input string name, input int n, input int upd,
                           input logic [3:0] old_w, input logic [3:0] new_w);
    logic [12:0] exp_v, got_v;
    logic [3:0]  er, ef;
    for (int e = 1; e <= n; e++) begin
      step();
      er = 4'b0; ef = 4'b0;
      if (e == upd) begin
        er = new_w & ~old_w;
        ef = ~new_w & old_w;
      end
      exp_v = {(e >= upd) ? new_w : old_w, |(er | ef), er, ef};
      got_v = {sensor_word, word_changed, rise, fall};
      tests_run++;
      if (got_v !== exp_v) begin
        failed++;
        $display("FAIL %s edge %0d: word/chg/rise/fall got %b/%b/%b/%b want %b/%b/%b/%b",
                 name, e, got_v[12:9], got_v[8], got_v[7:4], got_v[3:0],
                 exp_v[12:9], exp_v[8], exp_v[7:4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_raw(4'b1111);
    step(); step();
    tests_run++;
    if ({sensor_word, word_changed, rise, fall} !== 13'b0) begin
      failed++;
      $display("FAIL reset_hold: got %b/%b/%b/%b want 0000/0/0000/0000",
               sensor_word, word_changed, rise, fall);
    end
    reset_n = 1'b1;  // released mid-cycle, next edge is edge 1
    run_edges("reset_release", L + 2, L, 4'b0000, 4'b1111);
    set_raw(4'b0000);
    run_edges("reset_cleanup", L + 1, L, 4'b1111, 4'b0000);
  endtask

  task automatic test_giro();
    raw_giro = 1'b1;
    run_edges("giro_rise", L + 2, L, 4'b0000, 4'b1000);
    raw_giro = 1'b0;
    run_edges("giro_fall", L + 2, L, 4'b1000, 4'b0000);
  endtask

  task automatic test_glitch();
    // 3-cycle pulse is one short of the debounce window
    raw_metais = 1'b1;
    step(); step(); step();
    raw_metais = 1'b0;
    // 12 more edges, nothing may change (new_w == old_w)
    run_edges("metais_glitch", 12, 1, 4'b0000, 4'b0000);
  endtask

  task automatic test_bounce();
    raw_entrada = 1'b1;
    step(); step(); step();          // edges 1-3 high
    raw_entrada = 1'b0;
    step();                          // edge 4 low
    raw_entrada = 1'b1;              // sampled first on edge 5
    // edges 5..10 relative to edge 4: update on the 6th (absolute edge 10)
    run_edges("entrada_bounce", L + 1, L, 4'b0000, 4'b0100);
    raw_entrada = 1'b0;
    run_edges("entrada_cleanup", L + 1, L, 4'b0100, 4'b0000);
  endtask

  task automatic test_simultaneous();
    raw_giro    = 1'b1;
    raw_entrada = 1'b1;
    run_edges("simul_rise", L + 2, L, 4'b0000, 4'b1100);
    raw_giro    = 1'b0;
    raw_entrada = 1'b0;
    run_edges("simul_fall", L + 1, L, 4'b1100, 4'b0000);
  endtask

  task automatic test_reset_mid();
    raw_giro = 1'b1;
    run_edges("mid_setup", L + 1, L, 4'b0000, 4'b1000);
    raw_saida = 1'b1;
    step(); step(); step(); step();  // saida counter now at 2
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({sensor_word, word_changed, rise, fall} !== 13'b0) begin
      failed++;
      $display("FAIL mid_reset_async: got %b/%b/%b/%b want 0000/0/0000/0000",
               sensor_word, word_changed, rise, fall);
    end
    step();
    reset_n = 1'b1;
    // both held inputs re-acquired from scratch
    run_edges("mid_reacquire", L + 1, L, 4'b0000, 4'b1010);
    set_raw(4'b0000);
    run_edges("mid_cleanup", L + 1, L, 4'b1010, 4'b0000);
  endtask

  initial begin
    reset_n = 1'b0;
    set_raw(4'b0000);
    test_reset();
    test_giro();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
